// File: rtl/act_pwq_pkg.sv
// Shared constants for the PWQ tanh/sigmoid unit: mode encoding, segment bounds,
// saturation level and the Q8.24 Horner coefficient table.
package act_pwq_pkg;

  typedef enum logic {
    MODE_TANH    = 1'b0,
    MODE_SIGMOID = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    COEF_C2 = 2'd0,
    COEF_C1 = 2'd1,
    COEF_C0 = 2'd2
  } coef_sel_e;

  localparam int              FL_DEF = 24;
  localparam logic signed [31:0] ONE = 32'sh0100_0000;

  // k in units of 1.0 at fl fractional bits; segments split at 1, 2 and 4
  function automatic logic [63:0] seg_bound(input int unsigned k, input int unsigned fl);
    return 64'(k) << fl;
  endfunction

  function automatic logic [63:0] one_fx(input int unsigned fl);
    return 64'd1 << fl;
  endfunction

  function automatic logic signed [31:0] coef(input logic [1:0] seg, input coef_sel_e sel);
    logic signed [31:0] c;
    c = 32'sd0;
    case (seg)
      2'd0: case (sel)
        COEF_C2: c = -32'sh0027_A364;
        COEF_C1: c =  32'sh0100_0000;
        default: c =  32'sh0000_0000;
      endcase
      2'd1: case (sel)
        COEF_C2: c = -32'sh002B_5000;
        COEF_C1: c =  32'sh00B3_8270;
        default: c =  32'sh003B_F04C;
      endcase
      default: case (sel)
        COEF_C2: c = -32'sh0006_0000;
        COEF_C1: c =  32'sh0028_0000;
        default: c =  32'sh00BD_A7A2;
      endcase
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pwq_horner_stage.sv
// One Horner step: res = ((acc * x) >>> FL) + add, registered with a sideband.
// Loads only when en is high, so an unloaded stage holds its contents.
module pwq_horner_stage
  import act_pwq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FL    = 24,
  parameter int SB_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_vld,
  input  logic signed [WIDTH-1:0] in_acc,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_add,
  input  logic [SB_W-1:0]         in_sb,
  output logic                    out_vld,
  output logic signed [WIDTH-1:0] out_res,
  output logic [SB_W-1:0]         out_sb
);

  logic signed [2*WIDTH-1:0] prod;
  logic                      vld_d, vld_q;
  logic signed [WIDTH-1:0]   res_d, res_q;
  logic [SB_W-1:0]           sb_d, sb_q;

  always_comb begin
    prod  = (2*WIDTH)'(in_acc) * (2*WIDTH)'(in_x);
    vld_d = vld_q;
    res_d = res_q;
    sb_d  = sb_q;
    if (en) begin
      vld_d = in_vld;
      res_d = WIDTH'(prod >>> FL) + in_add;
      sb_d  = in_sb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
      sb_q  <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      sb_q  <= sb_d;
    end
  end

  assign out_vld = vld_q;
  assign out_res = res_q;
  assign out_sb  = sb_q;

endmodule

// File: rtl/act_pwq_pipe.sv
// Four-stage piecewise-quadratic tanh/sigmoid with valid/ready on both sides.
// Each stage advances when it is empty or the stage after it advances.
module act_pwq_pipe
  import act_pwq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FL    = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [WIDTH-1:0]        B1       = WIDTH'(seg_bound(1, FL));
  localparam logic [WIDTH-1:0]        B2       = WIDTH'(seg_bound(2, FL));
  localparam logic [WIDTH-1:0]        B4       = WIDTH'(seg_bound(4, FL));
  localparam logic signed [WIDTH-1:0] ONE_W    = WIDTH'(one_fx(FL));
  localparam logic signed [WIDTH-1:0] HALF_W   = WIDTH'(one_fx(FL) >> 1);
  localparam logic [WIDTH-1:0]        MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int SB2_W = TAG_W + 3;
  localparam int SB1_W = WIDTH + 2 + SB2_W;

  logic                    rdy0, rdy1, rdy2, rdy3;
  logic signed [WIDTH-1:0] u;
  logic                    v0_d, v0_q, sign_d, sign_q, sat0_d, sat0_q;
  logic [WIDTH-1:0]        abs_d, abs_q;
  logic [1:0]              seg_d, seg_q;
  mode_e                   mode0_d, mode0_q;
  logic [TAG_W-1:0]        tag0_d, tag0_q;

  logic                    v1, v2;
  logic signed [WIDTH-1:0] acc1, t2;
  logic [SB1_W-1:0]        sb1;
  logic [SB2_W-1:0]        sb2;

  logic                    out_valid_d, out_valid_q, out_sat_d, out_sat_q;
  logic [WIDTH-1:0]        out_data_d, out_data_q;
  logic [TAG_W-1:0]        out_tag_d, out_tag_q;
  logic signed [WIDTH-1:0] t3;

  assign rdy3     = !out_valid_q || out_ready;
  assign rdy2     = !v2 || rdy3;
  assign rdy1     = !v1 || rdy2;
  assign rdy0     = !v0_q || rdy1;
  assign in_ready = rdy0;

  // S0: sigmoid folds into tanh(x/2); classify |u| against the segment bounds
  always_comb begin
    u       = (in_mode == MODE_SIGMOID) ? ($signed(in_data) >>> 1) : $signed(in_data);
    v0_d    = v0_q;
    sign_d  = sign_q;
    abs_d   = abs_q;
    sat0_d  = sat0_q;
    seg_d   = seg_q;
    mode0_d = mode0_q;
    tag0_d  = tag0_q;
    if (rdy0) begin
      v0_d    = in_valid;
      sign_d  = u[WIDTH-1];
      abs_d   = sign_d ? -u : u;
      sat0_d  = ($unsigned(u) == MOST_NEG) || (abs_d >= B4);
      seg_d   = (abs_d < B1) ? 2'd0 : (abs_d < B2) ? 2'd1 : 2'd2;
      mode0_d = mode_e'(in_mode);
      tag0_d  = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= 1'b0;
      sign_q  <= 1'b0;
      abs_q   <= '0;
      sat0_q  <= 1'b0;
      seg_q   <= 2'd0;
      mode0_q <= MODE_TANH;
      tag0_q  <= '0;
    end else begin
      v0_q    <= v0_d;
      sign_q  <= sign_d;
      abs_q   <= abs_d;
      sat0_q  <= sat0_d;
      seg_q   <= seg_d;
      mode0_q <= mode0_d;
      tag0_q  <= tag0_d;
    end
  end

  pwq_horner_stage #(.WIDTH(WIDTH), .FL(FL), .SB_W(SB1_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy1),
    .in_vld  (v0_q),
    .in_acc  (WIDTH'(coef(seg_q, COEF_C2))),
    .in_x    ($signed(abs_q)),
    .in_add  (WIDTH'(coef(seg_q, COEF_C1))),
    .in_sb   ({abs_q, seg_q, sat0_q, mode0_q, sign_q, tag0_q}),
    .out_vld (v1),
    .out_res (acc1),
    .out_sb  (sb1)
  );

  pwq_horner_stage #(.WIDTH(WIDTH), .FL(FL), .SB_W(SB2_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy2),
    .in_vld  (v1),
    .in_acc  (acc1),
    .in_x    ($signed(sb1[SB1_W-1 -: WIDTH])),
    .in_add  (WIDTH'(coef(sb1[SB2_W +: 2], COEF_C0))),
    .in_sb   (sb1[SB2_W-1:0]),
    .out_vld (v2),
    .out_res (t2),
    .out_sb  (sb2)
  );

  // S3: sb2 = {sat, mode, sign, tag}
  always_comb begin
    t3 = sb2[TAG_W+2] ? ONE_W : t2;
    if (sb2[TAG_W]) t3 = -t3;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_tag_d   = out_tag_q;
    if (rdy3) begin
      out_valid_d = v2;
      if (v2) begin
        out_data_d = sb2[TAG_W+1] ? (t3 >>> 1) + HALF_W : t3;
        out_sat_d  = sb2[TAG_W+2];
        out_tag_d  = sb2[TAG_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_tag   = out_tag_q;

endmodule
